// File: rtl/seg_pkg.sv
// seg_pkg: constants and helpers shared by the 7-segment display blocks.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the glyph for nibble n (0..9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] HEX7_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [MAX_DIGITS-1:0] an_off(input int n);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low 7-segment decoder.
// Reused by every display block that needs a hex glyph.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_TAB[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment scanner with
// per-frame input snapshot, ghosting guard and PWM brightness.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIM_BITS    = 3,
    parameter int GUARD       = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic                    slot_tick,
    output logic                    frame_tick
);

    localparam int PH_LEN = REFRESH_DIV >> DIM_BITS;
    localparam int SUB_W  = $clog2(PH_LEN);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        NUM_DIGITS'(an_off(NUM_DIGITS));

    // The slot counter is kept as {phase, sub-count} so no divider is needed.
    logic [SUB_W-1:0]        sub_q, sub_d;
    logic [DIM_BITS-1:0]     ph_q, ph_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0] snap_dig_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [NUM_DIGITS-1:0]   snap_en_q;
    logic [DIM_BITS-1:0]     snap_br_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    st_q, ft_q;

    logic                    sub_last;
    logic                    slot_last;
    logic                    idx_last;
    logic                    frame_first;
    logic                    guard_ok;
    logic                    on;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;

    assign sub_last    = (sub_q == SUB_W'(PH_LEN - 1));
    assign slot_last   = sub_last && (&ph_q);
    assign idx_last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_first = (sub_q == '0) && (ph_q == '0) && (idx_q == '0);
    assign guard_ok    = (ph_q != '0) || (sub_q >= SUB_W'(GUARD));
    assign on          = snap_en_q[idx_q] && guard_ok && (ph_q <= snap_br_q);
    assign nib         = snap_dig_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nib_i (nib),
        .seg_o (seg_dec)
    );

    always_comb begin
        sub_d = sub_last ? '0 : sub_q + 1'b1;
        ph_d  = ph_q;
        idx_d = idx_q;
        if (sub_last) ph_d = ph_q + 1'b1;
        if (slot_last) idx_d = idx_last ? '0 : idx_q + 1'b1;

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (on) begin
            an_d[idx_q] = 1'b0;
            seg_d       = seg_dec;
            dp_d        = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q      <= '0;
            ph_q       <= '0;
            idx_q      <= '0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            snap_en_q  <= '0;
            snap_br_q  <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            st_q       <= 1'b0;
            ft_q       <= 1'b0;
        end else begin
            sub_q <= sub_d;
            ph_q  <= ph_d;
            idx_q <= idx_d;
            // Stale snapshot is hidden here because cnt 0 is inside the guard.
            if (frame_first) begin
                snap_dig_q <= digits;
                snap_dp_q  <= dp_in;
                snap_en_q  <= digit_en;
                snap_br_q  <= brightness;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            st_q  <= slot_last;
            ft_q  <= slot_last && idx_last;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign slot_tick  = st_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard plus vector table for seg_scan_driver.
// Small configuration: 4 digits, 16-cycle slots, 4 phases, guard 2.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 16;
    localparam int DB = 2;
    localparam int GD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [1:0]  brightness = '0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        slot_tick;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DIM_BITS    (DB),
        .GUARD       (GD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .slot_tick  (slot_tick),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       st;
        logic       ft;
    } exp_t;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  en;
        logic [3:0]  dpi;
        logic [1:0]  br;
        int          slot;
        int          cyc;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    localparam exp_t OFF = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

    function automatic logic [6:0] hex_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Reference model: expected output of the next cycle is queued at each edge.
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_dp = '0;
    logic [3:0]  s_en = '0;
    logic [1:0]  s_br = '0;
    exp_t        q[$];

    always @(posedge clk) begin
        exp_t e;
        logic lit;
        if (!rst_n) begin
            m_cnt = 0;
            m_idx = 0;
            s_dig = '0;
            s_dp  = '0;
            s_en  = '0;
            s_br  = '0;
            q.push_back(OFF);
        end else begin
            lit = s_en[m_idx] && (m_cnt >= GD) &&
                  ((m_cnt / (RD >> DB)) <= int'(s_br));
            e = OFF;
            if (lit) begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = hex_ref(s_dig[4*m_idx +: 4]);
                e.dp  = ~s_dp[m_idx];
            end
            e.st = (m_cnt == RD - 1);
            e.ft = e.st && (m_idx == ND - 1);
            q.push_back(e);
            if (m_cnt == 0 && m_idx == 0) begin
                s_dig = digits;
                s_dp  = dp_in;
                s_en  = digit_en;
                s_br  = brightness;
            end
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!rst_n) e = OFF;
            a = {AN, SEG, DP, slot_tick, frame_tick};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t: got an=%h seg=%h dp=%b st=%b ft=%b, required an=%h seg=%h dp=%b st=%b ft=%b",
                         $time, a.an, a.seg, a.dp, a.st, a.ft,
                         e.an, e.seg, e.dp, e.st, e.ft);
            end
        end
        checks++;
        if ($countones(~AN) > 1) begin
            failures++;
            $display("FAIL one_hot_an t=%0t: AN=%b, required at most one low bit", $time, AN);
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic wait_frame(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        if (frame_tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s: frame_tick not seen within %0d cycles", nm, n);
        end
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        int n;
        n = 0;
        while (AN !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (AN !== v) begin
            checks++;
            failures++;
            $display("FAIL %s: AN=%b never reached %b", nm, AN, v);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        vec_t vt[19];
        int   dark;
        int   first;
        int   lit_n;
        int   seg_bad;
        int   n;

        vt[0]  = '{16'h4321, 4'hF, 4'h0, 2'd3, 0,  8, 4'hE, 7'h79, 1'b1};
        vt[1]  = '{16'h4321, 4'hF, 4'h0, 2'd3, 3, 15, 4'h7, 7'h19, 1'b1};
        vt[2]  = '{16'h4321, 4'hF, 4'h0, 2'd0, 1,  2, 4'hF, 7'h7F, 1'b1};
        vt[3]  = '{16'h4321, 4'hF, 4'h0, 2'd0, 1,  3, 4'hD, 7'h24, 1'b1};
        vt[4]  = '{16'h4321, 4'hF, 4'h0, 2'd0, 1,  4, 4'hD, 7'h24, 1'b1};
        vt[5]  = '{16'h4321, 4'hF, 4'h0, 2'd0, 1,  5, 4'hF, 7'h7F, 1'b1};
        vt[6]  = '{16'hCDEF, 4'h5, 4'h1, 2'd3, 0,  8, 4'hE, 7'h0E, 1'b0};
        vt[7]  = '{16'hCDEF, 4'h5, 4'h1, 2'd3, 1,  8, 4'hF, 7'h7F, 1'b1};
        vt[8]  = '{16'hCDEF, 4'h5, 4'h1, 2'd3, 2,  8, 4'hB, 7'h21, 1'b1};
        vt[9]  = '{16'h89AB, 4'hF, 4'h8, 2'd1, 3,  8, 4'h7, 7'h00, 1'b0};
        vt[10] = '{16'h89AB, 4'hF, 4'h8, 2'd1, 3,  9, 4'hF, 7'h7F, 1'b1};
        vt[11] = '{16'h89AB, 4'hF, 4'h8, 2'd1, 0,  8, 4'hE, 7'h03, 1'b1};
        vt[12] = '{16'h89AB, 4'hF, 4'h8, 2'd1, 1,  1, 4'hF, 7'h7F, 1'b1};
        vt[13] = '{16'h5670, 4'hF, 4'h0, 2'd2, 1,  6, 4'hD, 7'h78, 1'b1};
        vt[14] = '{16'h5670, 4'hF, 4'h0, 2'd2, 2, 12, 4'hB, 7'h02, 1'b1};
        vt[15] = '{16'h5670, 4'hF, 4'h0, 2'd2, 3, 13, 4'hF, 7'h7F, 1'b1};
        vt[16] = '{16'h5670, 4'hF, 4'h0, 2'd2, 0,  6, 4'hE, 7'h40, 1'b1};
        vt[17] = '{16'h5670, 4'hF, 4'h0, 2'd2, 3,  6, 4'h7, 7'h12, 1'b1};
        vt[18] = '{16'h89AB, 4'hA, 4'h0, 2'd3, 1,  8, 4'hD, 7'h08, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_an", 32'(AN), 32'hF);
        check("reset_seg", 32'(SEG), 32'h7F);
        check("reset_dp", 32'(DP), 32'h1);
        check("reset_ticks", 32'({slot_tick, frame_tick}), 32'h0);

        // Release in cycle 0; inputs arrive after the first snapshot.
        rst_n = 1'b1;
        dark = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 2) begin
                digits     = 16'h4321;
                digit_en   = 4'hF;
                dp_in      = 4'h0;
                brightness = 2'd3;
            end
            if (AN !== 4'hF) dark++;
        end
        check("frame1_dark", 32'(dark), 32'd0);
        check("frame1_end_tick", 32'(frame_tick), 32'h1);

        first = -1;
        lit_n = 0;
        seg_bad = 0;
        for (int k = 65; k <= 80; k++) begin
            @(negedge clk);
            if (AN === 4'hE) begin
                lit_n++;
                if (first < 0) first = k;
                if (SEG !== 7'h79) seg_bad++;
            end
        end
        check("frame2_slot0_start", 32'(first), 32'd67);
        check("frame2_slot0_len", 32'(lit_n), 32'd14);
        check("frame2_slot0_seg", 32'(seg_bad), 32'd0);

        for (int i = 0; i < 19; i++) begin
            digits     = vt[i].dig;
            digit_en   = vt[i].en;
            dp_in      = vt[i].dpi;
            brightness = vt[i].br;
            wait_frame($sformatf("vec%0d_frame", i));
            repeat (vt[i].slot * RD + vt[i].cyc) @(negedge clk);
            check($sformatf("vec%0d_an", i), 32'(AN), 32'(vt[i].an));
            check($sformatf("vec%0d_seg", i), 32'(SEG), 32'(vt[i].seg));
            check($sformatf("vec%0d_dp", i), 32'(DP), 32'(vt[i].dpo));
        end

        // Mid-frame input change must wait for the next snapshot.
        digits     = 16'h0000;
        digit_en   = 4'hF;
        dp_in      = 4'h0;
        brightness = 2'd3;
        wait_frame("midframe_frame");
        wait_an(4'b1011, "midframe_slot2");
        digits = 16'hFFFF;
        check("midframe_slot2_seg", 32'(SEG), 32'h40);
        wait_an(4'b0111, "midframe_slot3");
        check("midframe_slot3_seg", 32'(SEG), 32'h40);
        wait_frame("midframe_next");
        wait_an(4'b1110, "midframe_next_slot0");
        check("midframe_next_seg", 32'(SEG), 32'h0E);

        // Asynchronous reset in the middle of a lit slot.
        wait_an(4'b1011, "rst_slot2");
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(AN), 32'hF);
        check("async_rst_seg", 32'(SEG), 32'h7F);
        check("async_rst_dp", 32'(DP), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (slot_tick !== 1'b1 && n < 40);
        check("rst_first_slot_tick", 32'(n), 32'd16);

        repeat (200) @(negedge clk);
        finish_run();
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: run did not complete in time");
        finish_run();
    end

endmodule
